dsp_mac_slice: RTL and testbench

Parametrised, three-stage pipelined multiply-accumulate slice, successor to the fixed 18x18/48-bit DSP slice. Adds generic operand widths, a per-sample valid pipeline, a global clock enable, and selectable saturating arithmetic with overflow flagging. Used standalone or chained through BCOUT/PCOUT into filter and accumulator arrays.

---
 rtl/dsp_mac_pkg.sv | 27 ++
 rtl/dsp_post_adder.sv | 51 +++++
 rtl/dsp_mac_slice.sv | 169 ++++++++++++++++
 tb/tb_dsp_mac_slice.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared MODE field layout, Z-select codes and saturation limits for the MAC slice.
package dsp_mac_pkg;

    localparam int MODE_W       = 5;
    localparam int MODE_ZSEL_LO = 0;
    localparam int MODE_ZSEL_HI = 1;
    localparam int MODE_SUB     = 2;
    localparam int MODE_PRE_EN  = 3;
    localparam int MODE_PRE_SUB = 4;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b01;
    localparam logic [1:0] Z_C    = 2'b10;
    localparam logic [1:0] Z_PCIN = 2'b11;

    // Widest result the limit helpers can describe; callers keep the low pw bits.
    localparam int SAT_FW = 128;

    function automatic logic [SAT_FW-1:0] sat_max(input int pw);
        sat_max = (128'd1 << (pw - 1)) - 128'd1;
    endfunction

    function automatic logic [SAT_FW-1:0] sat_min(input int pw);
        sat_min = 128'd1 << (pw - 1);
    endfunction

endpackage

// File: rtl/dsp_post_adder.sv
// Combinational post-adder: Z +/- (M + CIN) with carry, signed overflow and optional clamping.
module dsp_post_adder
    import dsp_mac_pkg::*;
#(
    parameter int PW  = 48,
    parameter int SAT = 0
) (
    input  logic [PW-1:0] z,
    input  logic [PW-1:0] m,
    input  logic          cin,
    input  logic          sub,
    output logic [PW-1:0] result,
    output logic          carry,
    output logic          ovf
);

    localparam logic [PW-1:0] LIM_HI = PW'(sat_max(PW));
    localparam logic [PW-1:0] LIM_LO = PW'(sat_min(PW));

    logic [PW-1:0] mc_s;
    logic [PW:0]   usum_s;
    logic          op_msb_s;

    // Unsigned sum in both forms; subtraction adds the complement of (M + CIN) plus one.
    always_comb begin
        mc_s     = m + {{(PW-1){1'b0}}, cin};
        usum_s   = '0;
        op_msb_s = 1'b0;
        if (sub) begin
            usum_s   = {1'b0, z} + {1'b0, ~mc_s} + {{PW{1'b0}}, 1'b1};
            op_msb_s = ~mc_s[PW-1];
        end else begin
            usum_s   = {1'b0, z} + {1'b0, m} + {{PW{1'b0}}, cin};
            op_msb_s = m[PW-1];
        end
    end

    assign carry = usum_s[PW];
    // Same-signed operands giving a differently-signed result is the only overflow case.
    assign ovf   = (z[PW-1] == op_msb_s) && (usum_s[PW-1] != z[PW-1]);

    // On overflow the true result carries the sign of z, which picks the clamp direction.
    always_comb begin
        if ((SAT != 0) && ovf) begin
            result = z[PW-1] ? LIM_LO : LIM_HI;
        end else begin
            result = usum_s[PW-1:0];
        end
    end

endmodule

// File: rtl/dsp_mac_slice.sv
// Three-stage pipelined multiply-accumulate slice with pre-adder, cascade in/out and
// optional saturation; a global clock enable freezes the whole pipeline.
module dsp_mac_slice
    import dsp_mac_pkg::*;
#(
    parameter int AW  = 18,
    parameter int BW  = 18,
    parameter int PW  = 48,
    parameter int SAT = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [AW-1:0]     a,
    input  logic [BW-1:0]     b,
    input  logic [BW-1:0]     d,
    input  logic [PW-1:0]     c,
    input  logic [PW-1:0]     pcin,
    input  logic              carryin,
    input  logic [MODE_W-1:0] mode,
    output logic [BW-1:0]     bcout,
    output logic [PW-1:0]     p,
    output logic [PW-1:0]     pcout,
    output logic              out_valid,
    output logic              carryout,
    output logic              ovf
);

    localparam int MW = AW + BW + 1;

    generate
        if (PW < MW) begin : g_pw_too_small
            $error("dsp_mac_slice: PW must be at least AW+BW+1");
        end
        if (PW > SAT_FW) begin : g_pw_too_large
            $error("dsp_mac_slice: PW exceeds saturation helper width");
        end
    endgenerate

    logic signed [AW-1:0]   a_r;
    logic signed [BW-1:0]   b_r, d_r;
    logic [PW-1:0]          c_r, pcin_r;
    logic                   cin_r, v1_r;
    logic [MODE_W-1:0]      mode_r;

    logic signed [BW:0]     preadd_s;
    logic signed [MW-1:0]   prod_s;

    logic signed [MW-1:0]   m_r;
    logic [PW-1:0]          c2_r, pcin2_r;
    logic                   cin2_r, v2_r;
    logic [MODE_SUB:0]      mode2_r;

    logic [PW-1:0]          z_s, m_ext_s, sum_s;
    logic                   carry_s, ovf_s;

    logic [PW-1:0]          p_r;
    logic                   carryout_r, ovf_r, out_valid_r;

    // Stage 1: capture every operand and the sample qualifier.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r    <= '0;
            b_r    <= '0;
            d_r    <= '0;
            c_r    <= '0;
            pcin_r <= '0;
            cin_r  <= 1'b0;
            mode_r <= '0;
            v1_r   <= 1'b0;
        end else if (ce) begin
            a_r    <= a;
            b_r    <= b;
            d_r    <= d;
            c_r    <= c;
            pcin_r <= pcin;
            cin_r  <= carryin;
            mode_r <= mode;
            v1_r   <= in_valid;
        end
    end

    // Pre-adder widened by one bit so D+B and D-B never truncate.
    always_comb begin
        preadd_s = {b_r[BW-1], b_r};
        if (mode_r[MODE_PRE_EN]) begin
            if (mode_r[MODE_PRE_SUB]) begin
                preadd_s = {d_r[BW-1], d_r} - {b_r[BW-1], b_r};
            end else begin
                preadd_s = {d_r[BW-1], d_r} + {b_r[BW-1], b_r};
            end
        end else begin
            preadd_s = {b_r[BW-1], b_r};
        end
    end

    assign prod_s = MW'(a_r) * MW'(preadd_s);

    // Stage 2: product plus the post-add controls travelling alongside it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_r     <= '0;
            c2_r    <= '0;
            pcin2_r <= '0;
            cin2_r  <= 1'b0;
            mode2_r <= '0;
            v2_r    <= 1'b0;
        end else if (ce) begin
            m_r     <= prod_s;
            c2_r    <= c_r;
            pcin2_r <= pcin_r;
            cin2_r  <= cin_r;
            mode2_r <= mode_r[MODE_SUB:0];
            v2_r    <= v1_r;
        end
    end

    // Z uses the live P register so consecutive accumulate samples need no bubble.
    always_comb begin
        case (mode2_r[MODE_ZSEL_HI:MODE_ZSEL_LO])
            Z_ZERO:  z_s = '0;
            Z_P:     z_s = p_r;
            Z_C:     z_s = c2_r;
            Z_PCIN:  z_s = pcin2_r;
            default: z_s = '0;
        endcase
    end

    assign m_ext_s = PW'(m_r);

    dsp_post_adder #(
        .PW  (PW),
        .SAT (SAT)
    ) u_post_adder (
        .z      (z_s),
        .m      (m_ext_s),
        .cin    (cin2_r),
        .sub    (mode2_r[MODE_SUB]),
        .result (sum_s),
        .carry  (carry_s),
        .ovf    (ovf_s)
    );

    // Stage 3: results load only for valid samples; bubbles leave P and flags untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_r         <= '0;
            carryout_r  <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (ce) begin
            out_valid_r <= v2_r;
            if (v2_r) begin
                p_r        <= sum_s;
                carryout_r <= carry_s;
                ovf_r      <= ovf_s;
            end
        end
    end

    assign bcout     = b_r;
    assign p         = p_r;
    assign pcout     = p_r;
    assign out_valid = out_valid_r;
    assign carryout  = carryout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Bench for dsp_mac_slice: a wrap instance cascaded into a saturating instance, checked
// every cycle against a sample-level arithmetic model plus directed literal scenarios.
module tb_dsp_mac_slice;

    typedef struct packed {
        logic        v;
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic [47:0] pcin;
        logic        cin;
        logic [4:0]  mode;
    } samp_t;

    typedef struct packed {
        logic        cy;
        logic        ov;
        logic [47:0] p;
    } res_t;

    logic  clk = 1'b0;
    logic  rstn = 1'b1;
    logic  ce = 1'b1;
    logic  checking = 1'b0;
    samp_t in0 = '0;
    samp_t in1 = '0;
    int    n_checks = 0;
    int    n_errors = 0;

    logic [17:0] bc_o[2];
    logic [47:0] p_o[2];
    logic [47:0] pc_o[2];
    logic        ov_o[2];
    logic        cy_o[2];
    logic        of_o[2];

    always #5 clk = ~clk;

    dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .SAT(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in0.v), .a(in0.a), .b(in0.b),
        .d(in0.d), .c(in0.c), .pcin(in0.pcin), .carryin(in0.cin), .mode(in0.mode),
        .bcout(bc_o[0]), .p(p_o[0]), .pcout(pc_o[0]), .out_valid(ov_o[0]),
        .carryout(cy_o[0]), .ovf(of_o[0])
    );

    dsp_mac_slice #(.AW(18), .BW(18), .PW(48), .SAT(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in1.v), .a(in1.a), .b(in1.b),
        .d(in1.d), .c(in1.c), .pcin(pc_o[0]), .carryin(in1.cin), .mode(in1.mode),
        .bcout(bc_o[1]), .p(p_o[1]), .pcout(pc_o[1]), .out_valid(ov_o[1]),
        .carryout(cy_o[1]), .ovf(of_o[1])
    );

    // Result of one sample evaluated with plain wide integer arithmetic.
    function automatic res_t eval(input samp_t s, input logic [47:0] p_now, input logic sat);
        logic signed [63:0] av, bv, dv, pre, m, z, ci, tot;
        logic [63:0] zu, mu, mcu;
        res_t r;
        av  = 64'($signed(s.a));
        bv  = 64'($signed(s.b));
        dv  = 64'($signed(s.d));
        ci  = 64'(s.cin);
        pre = s.mode[3] ? (s.mode[4] ? dv - bv : dv + bv) : bv;
        m   = av * pre;
        case (s.mode[1:0])
            2'd0:    z = 64'sd0;
            2'd1:    z = 64'($signed(p_now));
            2'd2:    z = 64'($signed(s.c));
            default: z = 64'($signed(s.pcin));
        endcase
        tot  = s.mode[2] ? z - (m + ci) : z + m + ci;
        r.ov = (tot > 64'sd140737488355327) || (tot < -64'sd140737488355328);
        r.p  = tot[47:0];
        if (sat && r.ov) r.p = tot[63] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
        zu = z & 64'h0000_FFFF_FFFF_FFFF;
        mu = m & 64'h0000_FFFF_FFFF_FFFF;
        mcu = (m + ci) & 64'h0000_FFFF_FFFF_FFFF;
        if (s.mode[2]) r.cy = (zu >= mcu);
        else           r.cy = ((zu + mu + 64'(s.cin)) >= 64'h0001_0000_0000_0000);
        return r;
    endfunction

    samp_t       st1[2];
    samp_t       st2[2];
    samp_t       cap1;
    res_t        nxt[2];
    logic [47:0] mp[2];
    logic        mov[2], mcy[2], movf[2];

    always_comb begin
        cap1      = in1;
        cap1.pcin = mp[0];
        for (int i = 0; i < 2; i++) nxt[i] = eval(st2[i], mp[i], (i == 1));
    end

    // Model: three-edge sample delay line; a sample leaving it updates P and the flags.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                mp[i] <= '0; mov[i] <= 1'b0; mcy[i] <= 1'b0; movf[i] <= 1'b0;
                st1[i] <= '0; st2[i] <= '0;
            end
        end else if (ce) begin
            for (int i = 0; i < 2; i++) begin
                if (st2[i].v) begin
                    mp[i] <= nxt[i].p; mcy[i] <= nxt[i].cy; movf[i] <= nxt[i].ov;
                end
                mov[i] <= st2[i].v;
                st2[i] <= st1[i];
            end
            st1[0] <= in0;
            st1[1] <= cap1;
        end
    end

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                chk("p", i, 64'(p_o[i]), 64'(mp[i]));
                chk("pcout", i, 64'(pc_o[i]), 64'(mp[i]));
                chk("out_valid", i, 64'(ov_o[i]), 64'(mov[i]));
                chk("carryout", i, 64'(cy_o[i]), 64'(mcy[i]));
                chk("ovf", i, 64'(of_o[i]), 64'(movf[i]));
                chk("bcout", i, 64'(bc_o[i]), 64'(st1[i].b));
            end
        end
    end

    function automatic samp_t mk(input logic v, input logic [17:0] a, input logic [17:0] b,
                                 input logic [17:0] d, input logic [47:0] c, input logic [4:0] mode);
        samp_t s;
        s = '0;
        s.v = v; s.a = a; s.b = b; s.d = d; s.c = c; s.mode = mode;
        return s;
    endfunction

    function automatic samp_t rnd();
        samp_t s;
        logic [63:0] t1, t2;
        t1 = {$urandom, $urandom};
        t2 = {$urandom, $urandom};
        s.v = ($urandom_range(0, 3) != 0);
        s.a = 18'($urandom);
        s.b = 18'($urandom);
        s.d = 18'($urandom);
        s.cin = 1'($urandom);
        s.mode = 5'($urandom);
        case ($urandom_range(0, 2))
            0:       s.c = t1[47:0];
            1:       s.c = 48'h7FFF_FFFF_FF00 + 48'(t1[7:0]);
            default: s.c = 48'h8000_0000_0000 + 48'(t1[7:0]);
        endcase
        s.pcin = ($urandom_range(0, 1) == 0) ? t2[47:0] : 48'h7FFF_FFFF_FFF0 + 48'(t2[3:0]);
        return s;
    endfunction

    task automatic do_reset();
        in0 = '0; in1 = '0; ce = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic async_reset_check();
        #2 rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_p", i, 64'(p_o[i]), 64'h0);
            chk("rst_pcout", i, 64'(pc_o[i]), 64'h0);
            chk("rst_out_valid", i, 64'(ov_o[i]), 64'h0);
            chk("rst_carryout", i, 64'(cy_o[i]), 64'h0);
            chk("rst_ovf", i, 64'(of_o[i]), 64'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [7:0]  acc_pat = 8'b0100_1101;
    logic [47:0] acc_p[8] = '{48'd14, 48'd14, 48'd28, 48'd42, 48'd42, 48'd42, 48'd56, 48'd56};

    initial begin
        #1 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        checking = 1'b1;
        chk("reset_p", 0, 64'(p_o[0]), 64'h0);
        chk("reset_valid", 0, 64'(ov_o[0]), 64'h0);

        // Plain multiply: 3 * 4, visible three edges later as a single-cycle pulse.
        in0 = mk(1'b1, 18'd3, 18'd4, 18'd0, 48'd0, 5'b00000);
        @(negedge clk);
        in0.v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mul_p", 0, 64'(p_o[0]), 64'd12);
        chk("mul_valid", 0, 64'(ov_o[0]), 64'd1);
        @(negedge clk);
        chk("mul_pulse_end", 0, 64'(ov_o[0]), 64'd0);
        chk("mul_hold", 0, 64'(p_o[0]), 64'd12);

        // Pre-adder D-B with Z=C subtract: 100 - (-5 * 8) = 140.
        in0 = mk(1'b1, -18'sd5, 18'd2, 18'd10, 48'd100, 5'b11110);
        @(negedge clk);
        in0.v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("preadd_p", 0, 64'(p_o[0]), 64'd140);

        // Accumulate 2*7 with gaps and one back-to-back pair.
        do_reset();
        for (int j = 0; j < 11; j++) begin
            if (j >= 3) begin
                chk("acc_p", 0, 64'(p_o[0]), 64'(acc_p[j-3]));
                chk("acc_valid", 0, 64'(ov_o[0]), 64'(acc_pat[j-3]));
            end
            if (j < 8) in0 = mk(acc_pat[j], 18'd2, 18'd7, 18'd0, 48'd0, 5'b00001);
            else       in0.v = 1'b0;
            @(negedge clk);
        end

        // Overflow of C + 1 at the positive limit: wrap on dut0, clamp on dut1.
        in0 = mk(1'b1, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 5'b00010);
        in1 = in0;
        @(negedge clk);
        in0.v = 1'b0;
        in1.v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_p", 0, 64'(p_o[0]), 64'h8000_0000_0000);
        chk("wrap_ovf", 0, 64'(of_o[0]), 64'd1);
        chk("sat_p", 1, 64'(p_o[1]), 64'h7FFF_FFFF_FFFF);
        chk("sat_ovf", 1, 64'(of_o[1]), 64'd1);

        // Clock-enable stall with two samples still in flight.
        do_reset();
        in0 = mk(1'b1, 18'd5, 18'd6, 18'd0, 48'd0, 5'b00000);
        @(negedge clk);
        in0 = mk(1'b1, 18'd7, 18'd8, 18'd0, 48'd0, 5'b00000);
        @(negedge clk);
        in0 = mk(1'b1, -18'sd3, 18'd9, 18'd0, 48'd0, 5'b00000);
        @(negedge clk);
        chk("stall_first", 0, 64'(p_o[0]), 64'd30);
        in0.v = 1'b0;
        ce = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_p", 0, 64'(p_o[0]), 64'd30);
            chk("stall_valid", 0, 64'(ov_o[0]), 64'd1);
        end
        ce = 1'b1;
        @(negedge clk);
        chk("resume_p1", 0, 64'(p_o[0]), 64'd56);
        @(negedge clk);
        chk("resume_p2", 0, 64'(p_o[0]), 64'hFFFF_FFFF_FFE5);
        chk("resume_valid", 0, 64'(ov_o[0]), 64'd1);
        @(negedge clk);
        chk("resume_end", 0, 64'(ov_o[0]), 64'd0);

        // Cascade: downstream Z=PCIN adds its own 2*5 to the upstream 12.
        do_reset();
        in0 = mk(1'b1, 18'd3, 18'd4, 18'd0, 48'd0, 5'b00000);
        @(negedge clk);
        in0.v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("casc_up", 0, 64'(p_o[0]), 64'd12);
        in1 = mk(1'b1, 18'd2, 18'd5, 18'd0, 48'd0, 5'b00011);
        @(negedge clk);
        in1.v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("casc_down", 1, 64'(p_o[1]), 64'd22);

        // Randomised traffic with random enable and an asynchronous reset mid-stream.
        for (int n = 0; n < 1500; n++) begin
            in0 = rnd();
            in1 = rnd();
            ce = ($urandom_range(0, 9) != 0);
            if (n == 600) async_reset_check();
            @(negedge clk);
        end

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
